// File: rtl/edge_point_reader.sv
// rtl/edge_point_reader.sv - raster-scans the labelled edge BRAM and streams (x,y) of pixels matching a bin
module edge_point_reader #(
    parameter int H_PIXELS     = 640,
    parameter int V_PIXELS     = 480,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  bin_sel,
    output logic [18:0] edge_addr_read,
    input  logic [2:0]  bram_read,
    output logic        point_valid,
    input  logic        point_ready,
    output logic [9:0]  point_x,
    output logic [8:0]  point_y,
    output logic [11:0] point_count,
    output logic        busy,
    output logic        done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [18:0] LAST_ADDR = 19'(H_PIXELS * V_PIXELS - 1);
    localparam logic [9:0]  LAST_X    = 10'(H_PIXELS - 1);
    localparam logic [8:0]  LAST_Y    = 9'(V_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      bin_q, bin_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic [18:0]     addr_q, addr_d;
    logic [11:0]     count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            pipe_v_q [READ_LATENCY];
    logic            pipe_v_d [READ_LATENCY];
    logic [9:0]      pipe_x_q [READ_LATENCY];
    logic [9:0]      pipe_x_d [READ_LATENCY];
    logic [8:0]      pipe_y_q [READ_LATENCY];
    logic [8:0]      pipe_y_d [READ_LATENCY];

    logic [18:0]     fifo_mem_q [FIFO_DEPTH];
    logic [18:0]     fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   free_cnt;
    logic            issue, push, pop;
    logic [18:0]     head;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pipe_v_d   = pipe_v_q;
        pipe_x_d   = pipe_x_q;
        pipe_y_d   = pipe_y_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_v_q[i]);
        end
        free_cnt = CW'(FIFO_DEPTH) - fifo_cnt_q;
        // Every read in flight has a reserved FIFO slot, so a push can never overflow.
        issue = (state_q == SCAN) && (free_cnt > inflight);
        head  = fifo_mem_q[rd_ptr_q];
        pop   = (fifo_cnt_q != '0) && point_ready;
        push  = pipe_v_q[READ_LATENCY-1] && (bram_read != 3'd0) &&
                ((bin_q == 3'd0) || (bram_read == bin_q));

        pipe_v_d[0] = issue;
        pipe_x_d[0] = x_q;
        pipe_y_d[0] = y_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_x_d[i] = pipe_x_q[i-1];
            pipe_y_d[i] = pipe_y_q[i-1];
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {pipe_y_q[READ_LATENCY-1], pipe_x_q[READ_LATENCY-1]};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (count_q != 12'hFFF) begin
                count_d = count_q + 12'd1;
            end
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_sel;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 19'd1;
                        if (x_q == LAST_X) begin
                            x_d = '0;
                            y_d = (y_q == LAST_Y) ? y_q : y_q + 9'd1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_cnt_q == '0)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            pipe_v_q   <= pipe_v_d;
            pipe_x_q   <= pipe_x_d;
            pipe_y_q   <= pipe_y_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign edge_addr_read = addr_q;
    assign point_valid    = (fifo_cnt_q != '0);
    assign point_x        = head[9:0];
    assign point_y        = head[18:10];
    assign point_count    = count_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_edge_point_reader.sv
// tb/tb_edge_point_reader.sv - scoreboard bench for edge_point_reader on a reduced 80x60 map
module tb_edge_point_reader;
    localparam int H    = 80;
    localparam int V    = 60;
    localparam int LAT  = 2;
    localparam int N    = H * V;
    localparam int LAST = N - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  bin_sel;
    logic [18:0] edge_addr_read;
    logic [2:0]  bram_read;
    logic        point_valid;
    logic        point_ready;
    logic [9:0]  point_x;
    logic [8:0]  point_y;
    logic [11:0] point_count;
    logic        busy;
    logic        done;

    edge_point_reader #(
        .H_PIXELS(H), .V_PIXELS(V), .READ_LATENCY(LAT), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_sel(bin_sel),
        .edge_addr_read(edge_addr_read), .bram_read(bram_read),
        .point_valid(point_valid), .point_ready(point_ready),
        .point_x(point_x), .point_y(point_y), .point_count(point_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [2:0] map_mem [N];
    logic [2:0] rd_d0, rd_d1;
    always @(posedge clk) begin
        rd_d0 <= (int'(edge_addr_read) < N) ? map_mem[edge_addr_read] : 3'd0;
        rd_d1 <= rd_d0;
    end
    assign bram_read = rd_d1;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q [$];

    int rdy_mode = 0;
    int rdy_cnt = 0;
    initial begin
        point_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rdy_cnt++;
            point_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_cnt % 4) == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [18:0] prev_head = '0;
    logic        prev_busy = 1'b0;
    logic [18:0] prev_addr = '0;
    int          max_addr = 0;
    int          hold_cnt = 0;
    int          bad_step = 0;
    logic [18:0] e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(point_valid), 32'd1);
                check("hold_data", 32'({point_y, point_x}), 32'(prev_head));
            end
            if (point_valid && point_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_point actual=(%0d,%0d) expected=none", point_x, point_y);
                end else begin
                    e = exp_q.pop_front();
                    check("point_xy", 32'({point_y, point_x}), 32'(e));
                end
            end
            prev_stall = point_valid && !point_ready;
            prev_head  = {point_y, point_x};
            if (busy) begin
                if (int'(edge_addr_read) > max_addr) max_addr = int'(edge_addr_read);
                if (prev_busy) begin
                    if (edge_addr_read == prev_addr) begin
                        if (int'(edge_addr_read) != LAST) hold_cnt++;
                    end else if (edge_addr_read != prev_addr + 19'd1) begin
                        bad_step++;
                    end
                end
            end
            prev_busy = busy;
            prev_addr = edge_addr_read;
        end else begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end
    end

    function automatic int idx(input int x, input int y);
        return y * H + x;
    endfunction

    task automatic clear_map();
        for (int i = 0; i < N; i++) map_mem[i] = 3'd0;
    endtask

    task automatic expect_pt(input int x, input int y);
        exp_q.push_back({9'(y), 10'(x)});
    endtask

    task automatic run_scan(input logic [2:0] bin, input int poke_at, output int n);
        max_addr = 0;
        hold_cnt = 0;
        bad_step = 0;
        @(negedge clk);
        bin_sel = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_addr", 32'(edge_addr_read), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("second_addr", 32'(edge_addr_read), 32'd1);
            if (n == poke_at) begin
                start = 1'b1;
                bin_sel = 3'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout actual=%0d expected=done", n);
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_max_addr", 32'(max_addr), 32'(LAST));
        check("end_addr_steps", 32'(bad_step), 32'd0);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin_sel = 3'd0;
        clear_map();
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(edge_addr_read), 32'd0);
        check("rst_valid", 32'(point_valid), 32'd0);
        check("rst_x", 32'(point_x), 32'd0);
        check("rst_y", 32'(point_y), 32'd0);
        check("rst_count", 32'(point_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty map: exact frame latency, nothing emitted, no issue stalls.
        run_scan(3'd1, -1, n);
        check("t1_cycles", 32'(n), 32'(N + LAT + 2));
        check("t1_count", 32'(point_count), 32'd0);
        check("t1_no_stall", 32'(hold_cnt), 32'd0);

        // Corner pixels in raster order.
        map_mem[idx(0, 0)]     = 3'd1;
        map_mem[idx(H-1, 0)]   = 3'd1;
        map_mem[idx(0, 1)]     = 3'd1;
        map_mem[idx(H-1, V-1)] = 3'd1;
        expect_pt(0, 0);
        expect_pt(H-1, 0);
        expect_pt(0, 1);
        expect_pt(H-1, V-1);
        run_scan(3'd1, -1, n);
        check("t2_count", 32'(point_count), 32'd4);

        clear_map();
        map_mem[idx(5, 5)] = 3'd2;
        map_mem[idx(6, 5)] = 3'd3;
        expect_pt(5, 5);
        expect_pt(6, 5);
        run_scan(3'd0, -1, n);
        check("t3_any_count", 32'(point_count), 32'd2);
        expect_pt(6, 5);
        run_scan(3'd3, -1, n);
        check("t3_bin3_count", 32'(point_count), 32'd1);

        // Dense row under 1-in-4 backpressure.
        clear_map();
        for (int x = 0; x < H; x++) begin
            map_mem[idx(x, 10)] = 3'd1;
            expect_pt(x, 10);
        end
        rdy_mode = 1;
        run_scan(3'd1, -1, n);
        rdy_mode = 0;
        check("t4_count", 32'(point_count), 32'(H));
        check("t4_addr_stalled", 32'(hold_cnt > 0), 32'd1);

        // Mid-scan reset aborts; a later point must not leak out.
        clear_map();
        map_mem[idx(0, 20)] = 3'd1;
        @(negedge clk);
        bin_sel = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_addr", 32'(edge_addr_read), 32'd0);
        check("t5_valid", 32'(point_valid), 32'd0);
        check("t5_count", 32'(point_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'd0);
        expect_pt(0, 20);
        run_scan(3'd1, -1, n);
        check("t5_rescan_count", 32'(point_count), 32'd1);

        // Full map with a start pulse mid-scan: count saturates, done holds.
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                map_mem[idx(x, y)] = 3'd1;
                expect_pt(x, y);
            end
        end
        run_scan(3'd0, 100, n);
        check("t6_count_sat", 32'(point_count), 32'd4095);
        repeat (10) @(negedge clk);
        check("t6_done_level", 32'(done), 32'd1);
        check("t6_count_hold", 32'(point_count), 32'd4095);
        clear_map();
        run_scan(3'd1, -1, n);
        check("t6_count_cleared", 32'(point_count), 32'd0);
        check("t6_cycles", 32'(n), 32'(N + LAT + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
